// File: rtl/alu_driver_if.sv
// Bundle of request, ALU and response signals around alu_driver.
// The slave modport is the driver; the master modport is its environment.
interface alu_driver_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_aluop;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic [2:0]       alu_aluop;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_valid_i;
  logic [31:0]      alu_f;
  logic             alu_valid_o;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_f;
  logic [TAG_W-1:0] rsp_tag;
  logic             err;

  modport slave (
    input  req_valid, req_aluop, req_a, req_b, req_tag,
    output req_ready,
    output alu_aluop, alu_a, alu_b, alu_valid_i,
    input  alu_f, alu_valid_o,
    output rsp_valid, rsp_f, rsp_tag, err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_aluop, req_a, req_b, req_tag,
    input  req_ready,
    input  alu_aluop, alu_a, alu_b, alu_valid_i,
    output alu_f, alu_valid_o,
    input  rsp_valid, rsp_f, rsp_tag, err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_driver.sv
// Request-side controller for the two-stage ALU: credit-limited issue,
// tag alignment with the ALU pipeline and an in-order response FIFO.
module alu_driver #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_driver_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic {FLUSH, RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_flush_cnt;
  logic [NW-1:0]    r_count;
  logic [NW-1:0]    r_inflight;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic             r_err;
  logic [31:0]      r_mem_f   [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];
  logic [TAG_W-1:0] r_tag_pipe[ALU_LAT];

  logic [NW:0]      w_sum;
  logic             w_run;
  logic             w_ready;
  logic             w_issue;
  logic             w_resp;
  logic             w_deq;
  logic             w_full;
  logic             w_enq;
  logic             w_ovf;
  logic             w_spur;

  // Credits come from registered state only, so a dequeue this cycle
  // frees a slot for issue no earlier than next cycle.
  assign w_sum   = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_run   = (r_state == RUN);
  assign w_ready = w_run && (w_sum < (NW+1)'(DEPTH));
  assign w_issue = bus.req_valid && w_ready;
  assign w_resp  = w_run && bus.alu_valid_o;
  assign w_deq   = (r_count != '0) && bus.rsp_ready;
  assign w_full  = (r_count == NW'(DEPTH));
  assign w_enq   = w_resp && (!w_full || w_deq);
  assign w_ovf   = w_resp && w_full && !w_deq;
  assign w_spur  = w_resp && (r_inflight == '0);

  assign bus.req_ready   = w_ready;
  assign bus.alu_valid_i = w_issue;
  assign bus.alu_aluop   = bus.req_aluop;
  assign bus.alu_a       = bus.req_a;
  assign bus.alu_b       = bus.req_b;
  assign bus.rsp_valid   = (r_count != '0);
  assign bus.rsp_f       = r_mem_f[r_rd];
  assign bus.rsp_tag     = r_mem_tag[r_rd];
  assign bus.err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FLUSH;
      r_flush_cnt <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flush_cnt == CW'(ALU_LAT - 1)) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase

      if (w_issue && !w_resp) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_issue && w_resp && (r_inflight != '0)) begin
        r_inflight <= r_inflight - 1'b1;
      end

      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - 1'b1;
      end

      if (w_enq) r_wr <= r_wr + 1'b1;
      if (w_deq) r_rd <= r_rd + 1'b1;
      if (w_spur || w_ovf) r_err <= 1'b1;
    end
  end

  // Stage 0 loads every edge regardless of issue; the last stage lines up
  // with alu_valid_o for the request that was issued ALU_LAT edges earlier.
  always_ff @(posedge clk) begin
    r_tag_pipe[0] <= bus.req_tag;
    for (int unsigned i = 1; i < ALU_LAT; i++) begin
      r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_f[r_wr]   <= bus.alu_f;
      r_mem_tag[r_wr] <= r_tag_pipe[ALU_LAT-1];
    end
  end

endmodule
